// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU definitions: operand width, ALU command codes and MIPS
// opcode/funct encodings. Used by the issue stage and the execute ALU.
package alu_issue_stage_pkg;

    localparam int ALU_DATA_WIDTH = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9,
        ALU_SLTU = 5'd10
    } alu_op_e;

    // primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // lui is executed as a shift of the zero-extended immediate
    localparam logic [4:0] LUI_SHAMT = 5'd16;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an instruction plus register operands into an
// ALU command. Unrecognised encodings yield a harmless zero add.
module alu_op_decode
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic [4:0]            alu_op,
    output logic [4:0]            shamt,
    output logic [DATA_WIDTH-1:0] src1,
    output logic [DATA_WIDTH-1:0] src2,
    output logic                  illegal
);

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [15:0]           imm;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_zext;
    logic                  unused_fields;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, imm};
    // register index fields are consumed by the register file, not here
    assign unused_fields = ^instr[25:16];

    // decode opcode/funct into operation, operands and shift amount
    always_comb begin
        alu_op  = ALU_ADD;
        shamt   = '0;
        src1    = rs_data;
        src2    = rt_data;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:  begin alu_op = ALU_SLL; shamt = instr[10:6];  end
                    FN_SRL:  begin alu_op = ALU_SRL; shamt = instr[10:6];  end
                    FN_SRA:  begin alu_op = ALU_SRA; shamt = instr[10:6];  end
                    FN_SLLV: begin alu_op = ALU_SLL; shamt = rs_data[4:0]; end
                    FN_SRLV: begin alu_op = ALU_SRL; shamt = rs_data[4:0]; end
                    FN_SRAV: begin alu_op = ALU_SRA; shamt = rs_data[4:0]; end
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                alu_op = ALU_ADD;
                src2   = imm_sext;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT;
                src2   = imm_sext;
            end
            OP_SLTIU: begin
                alu_op = ALU_SLTU;
                src2   = imm_sext;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                src2   = imm_zext;
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                src2   = imm_zext;
            end
            OP_XORI: begin
                alu_op = ALU_XOR;
                src2   = imm_zext;
            end
            OP_BEQ, OP_BNE: begin
                alu_op = ALU_SUB;
            end
            OP_LUI: begin
                alu_op = ALU_SLL;
                shamt  = LUI_SHAMT;
                src1   = '0;
                src2   = imm_zext;
            end
            default: illegal = 1'b1;
        endcase
        // illegal encodings must not leak register values downstream
        if (illegal) begin
            alu_op = ALU_ADD;
            shamt  = '0;
            src1   = '0;
            src2   = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the incoming instruction and holds the ALU
// command in a valid/ready pipeline register. Counts accepted illegal
// encodings for debug.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            ALUop,
    output logic [4:0]            shamt,
    output logic [DATA_WIDTH-1:0] src1,
    output logic [DATA_WIDTH-1:0] src2,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  illegal_cnt
);

    logic [4:0]            dec_alu_op;
    logic [4:0]            dec_shamt;
    logic [DATA_WIDTH-1:0] dec_src1;
    logic [DATA_WIDTH-1:0] dec_src2;
    logic                  dec_illegal;
    logic                  accept;
    logic                  cnt_sat;

    alu_op_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .alu_op  (dec_alu_op),
        .shamt   (dec_shamt),
        .src1    (dec_src1),
        .src2    (dec_src2),
        .illegal (dec_illegal)
    );

    // the slot frees up in the same cycle the consumer takes the command
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_sat  = (illegal_cnt == {CNT_WIDTH{1'b1}});

    // pipeline register and illegal counter: rst > flush > accept > drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            ALUop       <= '0;
            shamt       <= '0;
            src1        <= '0;
            src2        <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ALUop     <= dec_alu_op;
            shamt     <= dec_shamt;
            src1      <= dec_src1;
            src2      <= dec_src2;
            illegal   <= dec_illegal;
            if (dec_illegal && !cnt_sat) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  ALUop;
    logic [4:0]  shamt;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        illegal;
    logic [15:0] illegal_cnt;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] ILL_INSTR = 32'hFC00_0000;

    alu_issue_stage #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUop       (ALUop),
        .shamt       (shamt),
        .src1        (src1),
        .src2        (src2),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;
        step(); step();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
        total++; if (ALUop !== 5'd0) $display("FAIL reset_aluop got %0d want 0", ALUop); else passed++;
        total++; if ({shamt, src1, src2} !== '0) $display("FAIL reset_payload got %h/%h/%h want 0", shamt, src1, src2); else passed++;
        total++; if (illegal !== 1'b0 || illegal_cnt !== 16'd0) $display("FAIL reset_illegal got %0b/%0d want 0/0", illegal, illegal_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        drive({6'h08, 5'd16, 5'd9, 16'hFFFF}, 32'd5, 32'd77);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %0b want 1", out_valid); else passed++;
        total++; if (ALUop !== 5'd0 || src1 !== 32'd5 || src2 !== 32'hFFFF_FFFF)
            $display("FAIL addi_cmd got op=%0d s1=%h s2=%h want op=0 s1=5 s2=ffffffff", ALUop, src1, src2); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || src2 !== 32'hFFFF_FFFF)
            $display("FAIL drain_keep got v=%0b s2=%h want v=0 s2=ffffffff", out_valid, src2); else passed++;
    endtask

    task automatic test_lui_srav();
        drive({6'h0F, 5'd3, 5'd8, 16'h1234}, 32'hDEAD_BEEF, 32'h1);
        step();
        total++; if (ALUop !== 5'd7 || shamt !== 5'd16 || src1 !== 32'd0 || src2 !== 32'h0000_1234)
            $display("FAIL lui got op=%0d sh=%0d s1=%h s2=%h want 7/16/0/1234", ALUop, shamt, src1, src2); else passed++;
        drive({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 32'h23, 32'h8000_0000);
        step();
        total++; if (ALUop !== 5'd9 || shamt !== 5'd3 || src2 !== 32'h8000_0000)
            $display("FAIL srav got op=%0d sh=%0d s2=%h want 9/3/80000000", ALUop, shamt, src2); else passed++;
        drive({6'h00, 5'd0, 5'd2, 5'd3, 5'd5, 6'h00}, 32'h1F, 32'h0F);
        step();
        total++; if (ALUop !== 5'd7 || shamt !== 5'd5 || src2 !== 32'h0F)
            $display("FAIL sll got op=%0d sh=%0d s2=%h want 7/5/f", ALUop, shamt, src2); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_itype();
        drive({6'h0C, 5'd1, 5'd2, 16'h8001}, 32'hFFFF_FFFF, 32'd0);
        step();
        total++; if (ALUop !== 5'd2 || src1 !== 32'hFFFF_FFFF || src2 !== 32'h0000_8001)
            $display("FAIL andi got op=%0d s1=%h s2=%h want 2/ffffffff/8001", ALUop, src1, src2); else passed++;
        drive({6'h0B, 5'd1, 5'd2, 16'h8000}, 32'd4, 32'd0);
        step();
        total++; if (ALUop !== 5'd10 || src2 !== 32'hFFFF_8000)
            $display("FAIL sltiu got op=%0d s2=%h want 10/ffff8000", ALUop, src2); else passed++;
        drive({6'h04, 5'd1, 5'd2, 16'h0003}, 32'd7, 32'd9);
        step();
        total++; if (ALUop !== 5'd1 || src1 !== 32'd7 || src2 !== 32'd9 || shamt !== 5'd0)
            $display("FAIL beq got op=%0d s1=%h s2=%h sh=%0d want 1/7/9/0", ALUop, src1, src2, shamt); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive({6'h08, 5'd1, 5'd2, 16'h0010}, 32'd1, 32'd0);
        step();
        drive({6'h0D, 5'd2, 5'd3, 16'h00FF}, 32'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %0b want 0", i, in_ready); else passed++;
            step();
            total++; if (out_valid !== 1'b1 || ALUop !== 5'd0 || src1 !== 32'd1 || src2 !== 32'h10)
                $display("FAIL stall_hold[%0d] got v=%0b op=%0d s1=%h s2=%h want 1/0/1/10", i, out_valid, ALUop, src1, src2); else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %0b want 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || ALUop !== 5'd3 || src1 !== 32'd2 || src2 !== 32'hFF)
            $display("FAIL release_next got v=%0b op=%0d s1=%h s2=%h want 1/3/2/ff", out_valid, ALUop, src1, src2); else passed++;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive({6'h09, 5'd1, 5'd2, 16'h0001}, 32'd3, 32'd0);
        step();
        drive(ILL_INSTR, 32'd1, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else passed++;
        total++; if (illegal_cnt !== 16'd0 || illegal !== 1'b0)
            $display("FAIL flush_cnt got cnt=%0d ill=%0b want 0/0", illegal_cnt, illegal); else passed++;
    endtask

    task automatic test_illegal_reset();
        out_ready = 1'b1;
        drive(ILL_INSTR, 32'h1234_5678, 32'h9ABC_DEF0);
        step(); step(); step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (illegal !== 1'b1 || illegal_cnt !== 16'd3)
            $display("FAIL illegal_cnt got ill=%0b cnt=%0d want 1/3", illegal, illegal_cnt); else passed++;
        total++; if (ALUop !== 5'd0 || src1 !== 32'd0 || src2 !== 32'd0 || shamt !== 5'd0)
            $display("FAIL illegal_cmd got op=%0d s1=%h s2=%h sh=%0d want all 0", ALUop, src1, src2, shamt); else passed++;
        drive(32'h2001_0005, 32'd1, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || illegal !== 1'b0 || illegal_cnt !== 16'd0)
            $display("FAIL rst_mid got v=%0b ill=%0b cnt=%0d want 0/0/0", out_valid, illegal, illegal_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", in_ready); else passed++;
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        drive(ILL_INSTR, 32'd0, 32'd0);
        repeat (65535) @(posedge clk);
        #1;
        total++; if (illegal_cnt !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", illegal_cnt); else passed++;
        step(); step();
        in_valid = 1'b0;
        total++; if (illegal_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", illegal_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lui_srav();
        test_itype();
        test_stall();
        test_flush();
        test_illegal_reset();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
